rv32i_multicycle_ctrl: RTL and testbench

//  Multi-cycle control unit for the RV32I core; successor to the single-cycle combinational Control_Logic.
//  FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction over a variable-latency memory handshake.

---
 rtl/rv32i_multicycle_ctrl_pkg.sv | 66 ++++++
 rtl/rv32i_multicycle_ctrl_if.sv | 34 +++
 rtl/rv32i_ctrl_decode.sv | 83 ++++++++
 rtl/rv32i_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared types and helpers for the RV32I multi-cycle control unit.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
  } imm_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT   = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA   = 4'd7,
    ALU_OR   = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_sel_t;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0, CAUSE_ILLEGAL = 2'd1, CAUSE_TIMEOUT = 2'd2
  } trap_cause_t;

  // One-hot instruction class; all-zero means no legal opcode matched.
  typedef struct packed {
    logic op;
    logic opimm;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic fence;
  } instr_class_t;

  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic br_eq,
                                        input logic br_lt);
    logic taken;
    case (funct3)
      3'b000:         taken = br_eq;
      3'b001:         taken = ~br_eq;
      3'b100, 3'b110: taken = br_lt;
      3'b101, 3'b111: taken = ~br_lt;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and the datapath/memory.
interface rv32i_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        BrEq;
  logic        BrLT;
  logic        mem_ready;
  logic        mem_req;
  logic        PCWEn;
  logic        IRWEn;
  logic        PCSel;
  logic [2:0]  ImmSel;
  logic        RegWEn;
  logic        BrUn;
  logic        ASel;
  logic        BSel;
  logic [3:0]  ALUSel;
  logic        MemRW;
  logic [1:0]  WBSel;
  logic        retire;
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    input  instr, BrEq, BrLT, mem_ready,
    output mem_req, PCWEn, IRWEn, PCSel, ImmSel, RegWEn, BrUn, ASel, BSel,
           ALUSel, MemRW, WBSel, retire, trap, trap_cause
  );

  modport slave (
    output instr, BrEq, BrLT, mem_ready,
    input  mem_req, PCWEn, IRWEn, PCSel, ImmSel, RegWEn, BrUn, ASel, BSel,
           ALUSel, MemRW, WBSel, retire, trap, trap_cause
  );
endinterface

// File: rtl/rv32i_ctrl_decode.sv
// Combinational instruction classifier: class, legality and ALU/immediate selects.
module rv32i_ctrl_decode
  import rv32i_ctrl_pkg::*;
#(
  parameter bit FENCE_AS_NOP = 1'b1
) (
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output logic         illegal,
  output alu_sel_t     alu_sel,
  output imm_sel_t     imm_sel,
  output logic         a_sel,
  output logic         b_sel,
  output logic         br_un
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic       f7_ok;
  logic       shift;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  // Classify opcode, flag illegal encodings, derive datapath selects.
  always_comb begin
    cls         = '0;
    cls.op      = (opcode == OPC_OP);
    cls.opimm   = (opcode == OPC_OPIMM);
    cls.load    = (opcode == OPC_LOAD);
    cls.store   = (opcode == OPC_STORE);
    cls.branch  = (opcode == OPC_BRANCH);
    cls.jal     = (opcode == OPC_JAL);
    cls.jalr    = (opcode == OPC_JALR);
    cls.lui     = (opcode == OPC_LUI);
    cls.auipc   = (opcode == OPC_AUIPC);
    // SYSTEM and a disabled FENCE never get a class bit, so they fall out as illegal.
    cls.fence   = (opcode == OPC_FENCE) && FENCE_AS_NOP;

    alt   = (funct7 == 7'h20);
    f7_ok = (funct7 == 7'h00) || alt;
    shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    illegal = (cls == '0);
    if (cls.load && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)) illegal = 1'b1;
    if (cls.store && (funct3 > 3'd2)) illegal = 1'b1;
    if (cls.branch && (funct3 == 3'd2 || funct3 == 3'd3)) illegal = 1'b1;
    if (cls.jalr && (funct3 != 3'd0)) illegal = 1'b1;
    if (cls.op && (!f7_ok || (alt && funct3 != 3'd0 && funct3 != 3'd5))) illegal = 1'b1;
    if (cls.opimm && shift && (!f7_ok || (alt && funct3 != 3'd5))) illegal = 1'b1;

    alu_sel = ALU_ADD;
    if (cls.op || cls.opimm) begin
      case (funct3)
        3'd0:    alu_sel = (cls.op && alt) ? ALU_SUB : ALU_ADD;
        3'd1:    alu_sel = ALU_SLL;
        3'd2:    alu_sel = ALU_SLT;
        3'd3:    alu_sel = ALU_SLTU;
        3'd4:    alu_sel = ALU_XOR;
        3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
        3'd6:    alu_sel = ALU_OR;
        default: alu_sel = ALU_AND;
      endcase
    end
    if (cls.lui) alu_sel = ALU_PASSB;

    imm_sel = IMM_I;
    if (cls.store)              imm_sel = IMM_S;
    if (cls.branch)             imm_sel = IMM_B;
    if (cls.lui || cls.auipc)   imm_sel = IMM_U;
    if (cls.jal)                imm_sel = IMM_J;

    a_sel = cls.auipc || cls.jal || cls.branch;
    b_sel = ~cls.op;
    br_un = cls.branch && funct3[1];
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with variable-latency memory handshake and bus timeout.
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit FENCE_AS_NOP   = 1'b1
) (
  input logic clk,
  input logic rst,
  rv32i_multicycle_ctrl_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (TO_W > 0) ? TO_W : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t       state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  trap_cause_t  cause_q, cause_next;

  instr_class_t cls;
  logic         illegal;
  alu_sel_t     alu_sel;
  imm_sel_t     imm_sel;
  logic         a_sel, b_sel, br_un;
  logic         timed_out;
  logic         unused_cls;

  assign unused_cls = ^{cls.op, cls.opimm, cls.lui, cls.auipc};

  rv32i_ctrl_decode #(.FENCE_AS_NOP(FENCE_AS_NOP)) u_decode (
    .instr   (bus.instr),
    .cls     (cls),
    .illegal (illegal),
    .alu_sel (alu_sel),
    .imm_sel (imm_sel),
    .a_sel   (a_sel),
    .b_sel   (b_sel),
    .br_un   (br_un)
  );

  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

  // State, stall counter and latched trap cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      cause_q  <= cause_next;
    end
  end

  // Next-state and all control outputs.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    cause_next     = cause_q;
    bus.mem_req    = 1'b0;
    bus.PCWEn      = 1'b0;
    bus.IRWEn      = 1'b0;
    bus.PCSel      = 1'b0;
    bus.ImmSel     = '0;
    bus.RegWEn     = 1'b0;
    bus.BrUn       = 1'b0;
    bus.ASel       = 1'b0;
    bus.BSel       = 1'b0;
    bus.ALUSel     = '0;
    bus.MemRW      = 1'b0;
    bus.WBSel      = '0;
    bus.retire     = 1'b0;
    bus.trap       = 1'b0;
    bus.trap_cause = CAUSE_NONE;

    // Operand selects stay put from EXEC through WB so the ALU result
    // (data address, jump target, writeback value) is stable without an ALU-out register.
    if (state inside {ST_EXEC, ST_MEM, ST_WB}) begin
      bus.ImmSel = imm_sel;
      bus.ALUSel = alu_sel;
      bus.ASel   = a_sel;
      bus.BSel   = b_sel;
      bus.BrUn   = br_un;
    end

    case (state)
      ST_IDLE: state_next = ST_FETCH;

      ST_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWEn  = 1'b1;
          state_next = ST_DECODE;
        end else if (timed_out) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (TIMEOUT_CYCLES != 0) begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end

      ST_DECODE: begin
        if (illegal) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cls.branch) begin
          bus.PCSel  = branch_taken(bus.instr[14:12], bus.BrEq, bus.BrLT);
          bus.PCWEn  = 1'b1;
          bus.retire = 1'b1;
          state_next = ST_FETCH;
        end else if (cls.fence) begin
          bus.PCWEn  = 1'b1;
          bus.retire = 1'b1;
          state_next = ST_FETCH;
        end else if (cls.load || cls.store) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.MemRW   = cls.store;
        if (bus.mem_ready) begin
          if (cls.store) begin
            bus.PCWEn  = 1'b1;
            bus.retire = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timed_out) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (TIMEOUT_CYCLES != 0) begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end

      ST_WB: begin
        bus.RegWEn = 1'b1;
        bus.PCWEn  = 1'b1;
        bus.retire = 1'b1;
        if (cls.load) begin
          bus.WBSel = WB_MEM;
        end else if (cls.jal || cls.jalr) begin
          bus.WBSel = WB_PC4;
          bus.PCSel = 1'b1;
        end else begin
          bus.WBSel = WB_ALU;
        end
        state_next = ST_FETCH;
      end

      ST_TRAP: begin
        bus.trap       = 1'b1;
        bus.trap_cause = cause_q;
      end

      default: state_next = ST_IDLE;
    endcase

    // Any state change restarts the stall counter, covering every entry into FETCH and MEM.
    if (state_next != state) wait_cnt_next = '0;
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: stimulus pushes expected retire/trap
// records, a monitor pops one on every retire pulse or trap assertion.
module tb_rv32i_multicycle_ctrl;

  typedef struct {
    string      name;
    bit         is_trap;
    logic [1:0] cause;
    int         cycles;
    int         reqs;
    logic       memrw_any;
    logic       regwen;
    logic       pcwen;
    logic       pcsel;
    logic       brun;
    logic [1:0] wbsel;
    logic [3:0] alusel;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  rv32i_multicycle_ctrl_if bus ();

  rv32i_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .FENCE_AS_NOP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", tag, field, act, req);
    end
  endfunction

  function automatic logic [21:0] all_outs();
    return {bus.mem_req, bus.PCWEn, bus.IRWEn, bus.PCSel, bus.ImmSel, bus.RegWEn,
            bus.BrUn, bus.ASel, bus.BSel, bus.ALUSel, bus.MemRW, bus.WBSel,
            bus.retire, bus.trap, bus.trap_cause};
  endfunction

  function automatic exp_t mk(input string n, input int cyc, input int reqs,
                              input logic mrw, input logic rw, input logic pw,
                              input logic ps, input logic bu,
                              input logic [1:0] wb, input logic [3:0] alu);
    exp_t e;
    e.name = n; e.is_trap = 1'b0; e.cause = 2'd0; e.cycles = cyc; e.reqs = reqs;
    e.memrw_any = mrw; e.regwen = rw; e.pcwen = pw; e.pcsel = ps; e.brun = bu;
    e.wbsel = wb; e.alusel = alu;
    return e;
  endfunction

  function automatic exp_t mk_trap(input string n, input logic [1:0] cause,
                                   input int cyc, input int reqs);
    exp_t e;
    e = mk(n, cyc, reqs, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    e.is_trap = 1'b1;
    e.cause   = cause;
    return e;
  endfunction

  // Monitor: measures each instruction from its first mem_req cycle and
  // compares against the next queued expectation on retire or trap.
  initial begin : monitor
    bit   active;
    int   cyc, reqs;
    logic mrw, prev_trap;
    exp_t e;
    active = 0; cyc = 0; reqs = 0; mrw = 1'b0; prev_trap = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        active = 0;
        prev_trap = 1'b0;
        continue;
      end
      if (!active && bus.mem_req) begin
        active = 1; cyc = 0; reqs = 0; mrw = 1'b0;
      end
      if (active) begin
        cyc++;
        if (bus.mem_req) begin
          reqs++;
          if (bus.MemRW) mrw = 1'b1;
        end
      end
      if (bus.retire || (bus.trap && !prev_trap)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=retire%0d_trap%0d required=none",
                   bus.retire, bus.trap);
        end else begin
          e = exp_q.pop_front();
          chk(e.name, "trap", bus.trap, e.is_trap);
          chk(e.name, "trap_cause", bus.trap_cause, e.cause);
          chk(e.name, "cycles", cyc, e.cycles);
          chk(e.name, "mem_req_cycles", reqs, e.reqs);
          if (e.is_trap) begin
            chk(e.name, "mem_req", bus.mem_req, 0);
            chk(e.name, "PCWEn", bus.PCWEn, 0);
          end else begin
            chk(e.name, "memrw_seen", mrw, e.memrw_any);
            chk(e.name, "RegWEn", bus.RegWEn, e.regwen);
            chk(e.name, "PCWEn", bus.PCWEn, e.pcwen);
            chk(e.name, "PCSel", bus.PCSel, e.pcsel);
            chk(e.name, "BrUn", bus.BrUn, e.brun);
            chk(e.name, "WBSel", bus.WBSel, e.wbsel);
            chk(e.name, "ALUSel", bus.ALUSel, e.alusel);
          end
        end
        active = 0;
      end
      prev_trap = bus.trap;
    end
  end

  // Memory agent + instruction driver: fw/mw are stall cycles before mem_ready
  // for the fetch and the data access; stray drives mem_ready while mem_req is low.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic eq, input logic lt, input bit stray,
                           input exp_t e);
    int phase, waited;
    bit done;
    exp_q.push_back(e);
    phase = 0; waited = 0; done = 0;
    @(negedge clk);
    bus.instr = ins; bus.BrEq = eq; bus.BrLT = lt;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.mem_req) bus.mem_ready = (waited >= ((phase == 0) ? fw : mw));
      else             bus.mem_ready = stray;
      #2;
      if (bus.mem_req && !bus.mem_ready) waited++;
      else if (bus.mem_req) begin
        phase++;
        waited = 0;
      end
      if (bus.retire || bus.trap) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s.completion actual=none required=retire_or_trap_within_64", e.name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic post_trap(input string n);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      chk(n, "post_mem_req", bus.mem_req, 0);
      chk(n, "post_trap", bus.trap, 1);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.instr = '0; bus.BrEq = 1'b0; bus.BrLT = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk); #3;
    chk("reset", "all_outputs", all_outs(), 0);
    do_reset();

    // ALU / upper-immediate / jump classes, zero-wait and stalled
    run_instr(32'h003100B3, 0, 0, 0, 0, 0, mk("add",      4, 1, 0, 1, 1, 0, 0, 2'd1, 4'd0));
    run_instr(32'h003100B3, 1, 0, 0, 0, 1, mk("add_stall",5, 2, 0, 1, 1, 0, 0, 2'd1, 4'd0));
    run_instr(32'h403100B3, 0, 0, 0, 0, 0, mk("sub",      4, 1, 0, 1, 1, 0, 0, 2'd1, 4'd1));
    run_instr(32'h003130B3, 0, 0, 0, 0, 0, mk("sltu",     4, 1, 0, 1, 1, 0, 0, 2'd1, 4'd4));
    run_instr(32'h4010D093, 0, 0, 0, 0, 0, mk("srai",     4, 1, 0, 1, 1, 0, 0, 2'd1, 4'd7));
    run_instr(32'h123450B7, 0, 0, 0, 0, 0, mk("lui",      4, 1, 0, 1, 1, 0, 0, 2'd1, 4'd10));
    run_instr(32'h00C000EF, 0, 0, 0, 0, 0, mk("jal",      4, 1, 0, 1, 1, 1, 0, 2'd2, 4'd0));
    run_instr(32'h000080E7, 0, 0, 0, 0, 0, mk("jalr",     4, 1, 0, 1, 1, 1, 0, 2'd2, 4'd0));

    // Memory classes
    run_instr(32'h00412083, 0, 2, 0, 0, 0, mk("lw",       7, 4, 0, 1, 1, 0, 0, 2'd0, 4'd0));
    run_instr(32'h00112223, 0, 0, 0, 0, 0, mk("sw",       4, 2, 1, 0, 1, 0, 0, 2'd0, 4'd0));

    // Branches and FENCE
    run_instr(32'h00208863, 0, 0, 1, 0, 0, mk("beq_taken",3, 1, 0, 0, 1, 1, 0, 2'd0, 4'd0));
    run_instr(32'h00208863, 0, 0, 0, 0, 0, mk("beq_not",  3, 1, 0, 0, 1, 0, 0, 2'd0, 4'd0));
    run_instr(32'h0020E863, 0, 0, 0, 1, 0, mk("bltu",     3, 1, 0, 0, 1, 1, 1, 2'd0, 4'd0));
    run_instr(32'h0020D863, 0, 0, 0, 1, 0, mk("bge_not",  3, 1, 0, 0, 1, 0, 0, 2'd0, 4'd0));
    run_instr(32'h0000000F, 0, 0, 0, 0, 0, mk("fence",    3, 1, 0, 0, 1, 0, 0, 2'd0, 4'd0));

    // mem_ready arriving on the last allowed stall cycle beats the timeout
    run_instr(32'h003100B3, 15, 0, 0, 0, 0, mk("add_tie", 19, 16, 0, 1, 1, 0, 0, 2'd1, 4'd0));

    // Illegal instructions
    run_instr(32'h0000007F, 0, 0, 0, 0, 0, mk_trap("ill_opc", 2'd1, 3, 1));
    post_trap("ill_opc");
    do_reset();
    run_instr(32'h40109093, 0, 0, 0, 0, 0, mk_trap("ill_slli", 2'd1, 3, 1));
    do_reset();
    run_instr(32'h00000073, 0, 0, 0, 0, 0, mk_trap("ill_ecall", 2'd1, 3, 1));
    do_reset();

    // Fetch timeout after 16 stalled cycles
    run_instr(32'h003100B3, 1000, 0, 0, 0, 0, mk_trap("timeout", 2'd2, 17, 16));
    post_trap("timeout");
    do_reset();

    // Reset asserted while a store waits in MEM
    @(negedge clk);
    bus.instr = 32'h00112223;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      bus.mem_ready = bus.mem_req && !bus.MemRW;
      #2;
      if (bus.mem_req && bus.MemRW) break;
    end
    chk("rst_mid", "in_mem_store", {bus.mem_req, bus.MemRW}, 2'b11);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid", "all_outputs", all_outs(), 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #3;
    chk("rst_mid", "idle_mem_req", bus.mem_req, 0);
    @(negedge clk); #3;
    chk("rst_mid", "fetch_mem_req", bus.mem_req, 1);
    // The FETCH already sampled above stalls one cycle before this ADD is granted.
    run_instr(32'h003100B3, 0, 0, 0, 0, 0, mk("add_after_rst", 5, 2, 0, 1, 1, 0, 0, 2'd1, 4'd0));

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard.drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
